// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end: widths, reset PC, the
// canonical NOP and the {pc, instr} record carried by the fetch buffer.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte offset so an address points at a whole instruction word.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched instructions. Push, pop and flush are
// resolved in one cycle; the head entry is read straight from the storage
// registers, so it appears the cycle after it was pushed and never depends
// combinationally on this cycle's push inputs.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Qualify requests and compute the next pointers and occupancy.
  always_comb begin
    do_pop   = pop & (count_q != '0) & ~flush;
    // A push into a full buffer is only accepted when the head leaves together.
    do_push  = push & ~flush & ((count_q != FULL_COUNT) | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];
  assign count      = count_q;

  // The credit scheme upstream must never push into a full buffer on its own.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (push & ~flush) |-> ((count_q != FULL_COUNT) | pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Keeps the fetch PC, issues word-aligned requests
// to instruction memory, buffers returned words with their PCs and hands
// them to decode. A taken branch flushes the buffer, restarts fetch at the
// target and arranges for the wrong-path responses still in flight to be
// thrown away as they arrive.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 2 * XLEN;
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] START_PC  = RESET_PC & WORD_MASK;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   fifo_count;
  logic [CW:0]     inflight;
  logic [XLEN-1:0] redirect_pc;
  logic            req_fire;
  logic            keep_rsp;
  logic            pop;
  logic            head_valid;
  logic [EW-1:0]   head_data;
  logic [EW-1:0]   push_data;

  // Branch targets are word addresses; the low two bits are simply masked.
  assign redirect_pc = pc_target & WORD_MASK;

  // Requests in flight plus buffered entries may never exceed the buffer
  // size, so every response is guaranteed a slot. Only registered counts
  // feed this, keeping decode's ready off the request path.
  assign inflight       = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid = ~reset & ~pc_src & (inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response is kept only when nothing is pending discard and no redirect
  // is happening in the same cycle.
  assign keep_rsp  = imem_rsp_valid & ~pc_src & (drop_cnt_q == '0);
  assign push_data = {rsp_pc_q, imem_rsp_data};
  assign pop       = head_valid & instr_ready;

  assign instr_valid = head_valid;
  assign instr       = head_valid ? head_data[XLEN-1:0]  : '0;
  assign instr_pc    = head_valid ? head_data[EW-1:XLEN] : '0;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (keep_rsp),
    .push_data  (push_data),
    .pop        (pop),
    .flush      (pc_src),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  // Next-state for the fetch/response PCs and the in-flight bookkeeping.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (pc_src) begin
      // Everything still owed after this cycle belongs to the wrong path.
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (keep_rsp) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= START_PC;
      rsp_pc_q      <= START_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Interface sanity: a redirect always coincides with consuming the head,
  // memory never answers more than was asked, and addresses stay aligned.
  a_redirect_on_pop: assert property (@(posedge clk) disable iff (reset)
    pc_src |-> pop);
  a_no_extra_rsp: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (outstanding_q != '0));
  a_addr_aligned: assert property (@(posedge clk) disable iff (reset)
    imem_req_valid |-> (imem_req_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        pc_src;
  logic [31:0] pc_target;

  fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_src         (pc_src),
    .pc_target      (pc_target)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // ---------------- instruction memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pend_q[$];
  int mem_k = 1;
  int mem_rdy_mode = 0;   // 0 always ready, 1 every other cycle, 2 random
  int last_due = 0;

  initial begin
    pend_t p;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else begin
        case (mem_rdy_mode)
          0:       imem_req_ready = 1'b1;
          1:       imem_req_ready = (cyc % 2 == 0);
          default: imem_req_ready = ($urandom_range(0, 1) == 1);
        endcase
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_q[0].addr);
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
      end
      #4;
      if (reset) begin
        pend_q.delete();
        last_due = 0;
      end else begin
        if (imem_rsp_valid) void'(pend_q.pop_front());
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr_aligned", {30'd0, imem_req_addr[1:0]}, 32'd0);
          p.addr = imem_req_addr;
          p.due  = cyc + mem_k;
          if (p.due <= last_due) p.due = last_due + 1;
          last_due = p.due;
          pend_q.push_back(p);
          checks++;
          if (pend_q.size() > DEPTH) begin
            errors++;
            $display("FAIL outstanding_cap: got %0d outstanding, expected at most %0d", pend_q.size(), DEPTH);
          end
        end
      end
    end
  end

  // ---------------- decode-side stimulus ----------------
  int dec_rdy_pct = 100;
  int br_pct = 0;
  bit force_br_en = 1'b0;
  logic [31:0] force_br_pc = '0;
  logic [31:0] force_br_tgt = '0;

  initial begin
    int r;
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    pc_target   = '0;
    forever begin
      @(negedge clk);
      pc_src    = 1'b0;
      pc_target = $urandom;
      if (reset) begin
        instr_ready = 1'b0;
      end else begin
        r = int'($urandom_range(1, 100));
        instr_ready = (r <= dec_rdy_pct);
        if (instr_valid && instr_ready) begin
          r = int'($urandom_range(1, 100));
          if (force_br_en && instr_pc == force_br_pc) begin
            pc_src      = 1'b1;
            pc_target   = force_br_tgt;
            force_br_en = 1'b0;
          end else if (r <= br_pct) begin
            pc_src    = 1'b1;
            pc_target = $urandom_range(0, 4095);
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  // Architectural model: the next instruction decode sees is the previous
  // one + 4, or the word-aligned target when that one was a taken branch.
  logic [31:0] exp_q[$];
  bit          redir_pend = 1'b0;
  logic [31:0] redir_addr = '0;
  int          consumed = 0;

  initial begin
    logic [31:0] e;
    logic [31:0] nxt;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        check("reset_instr_valid", 32'(instr_valid), 32'd0);
        exp_q.delete();
        exp_q.push_back(RPC);
        redir_pend = 1'b0;
      end else begin
        if (redir_pend) begin
          check("redirect_req_valid", 32'(imem_req_valid), 32'd1);
          check("redirect_req_addr", imem_req_addr, redir_addr);
          redir_pend = 1'b0;
        end
        if (!instr_valid) begin
          check("idle_instr", instr, 32'd0);
          check("idle_instr_pc", instr_pc, 32'd0);
        end else if (instr_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got pc %h, expected nothing", instr_pc);
          end else begin
            e = exp_q.pop_front();
            check("instr_pc", instr_pc, e);
            check("instr", instr, mem_word(e));
            consumed++;
            if (pc_src) begin
              nxt = {pc_target[31:2], 2'b00};
              check("redirect_no_req", 32'(imem_req_valid), 32'd0);
              redir_pend = 1'b1;
              redir_addr = nxt;
            end else begin
              nxt = e + 32'd4;
            end
            exp_q.push_back(nxt);
          end
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int base;
    reset = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RPC);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // Release: first request immediately, then one instruction per cycle from cycle 3
    @(posedge clk);
    #1 reset = 1'b0;
    base = consumed;
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RPC);
    repeat (20) @(posedge clk);
    #2;
    check("throughput_count", 32'(consumed - base), 32'd18);

    // Decode stall: requests stop once the credit is used up, buffer holds
    dec_rdy_pct = 0;
    repeat (10) @(posedge clk);
    #2;
    check("stall_no_req", 32'(imem_req_valid), 32'd0);
    check("stall_holds_valid", 32'(instr_valid), 32'd1);
    dec_rdy_pct = 100;
    repeat (10) @(posedge clk);
    #2;

    // Mid-stream reset with requests outstanding and entries buffered
    mem_k = 2;
    dec_rdy_pct = 0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_instr_valid", 32'(instr_valid), 32'd0);
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_req_addr", imem_req_addr, RPC);
    dec_rdy_pct = 100;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_req_addr", imem_req_addr, RPC);

    // Taken branch at pc 8 with misaligned target 0x43 -> fetch resumes at 0x40
    force_br_pc  = 32'h8;
    force_br_tgt = 32'h43;
    force_br_en  = 1'b1;
    base = consumed;
    repeat (25) @(posedge clk);
    #2;
    check("branch_seen", 32'(force_br_en), 32'd0);
    checks++;
    if (consumed - base < 10) begin
      errors++;
      $display("FAIL branch_progress: got %0d instructions, expected at least 10", consumed - base);
    end

    // Randomized phases: latency, memory backpressure, decode stalls, branches
    base = consumed;
    for (int ph = 0; ph < 6; ph++) begin
      if (ph == 0) begin
        mem_k = 3;
        mem_rdy_mode = 1;
        dec_rdy_pct = 100;
        br_pct = 0;
      end else begin
        mem_k = int'($urandom_range(1, 4));
        mem_rdy_mode = int'($urandom_range(0, 2));
        dec_rdy_pct = int'($urandom_range(40, 100));
        br_pct = int'($urandom_range(5, 25));
      end
      repeat (400) @(posedge clk);
      #2;
    end
    checks++;
    if (consumed - base < 200) begin
      errors++;
      $display("FAIL random_progress: got %0d instructions, expected at least 200", consumed - base);
    end

    // Reset in the middle of random traffic
    reset = 1'b1;
    #1;
    check("rand_rst_instr_valid", 32'(instr_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rand_post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("rand_post_rst_req_addr", imem_req_addr, RPC);
    base = consumed;
    repeat (100) @(posedge clk);
    #2;
    checks++;
    if (consumed - base < 10) begin
      errors++;
      $display("FAIL final_progress: got %0d instructions, expected at least 10", consumed - base);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
